// File: rtl/aclk_lcd_pkg.sv
// aclk_lcd_pkg: sequencer states, HD44780 command/ASCII constants and byte selectors.
package aclk_lcd_pkg;
  typedef enum logic [1:0] {PWRUP, INIT, FRAME, IDLE} state_t;
  typedef struct packed {
    logic [7:0] ms_hr;
    logic [7:0] ls_hr;
    logic [7:0] ms_min;
    logic [7:0] ls_min;
    logic       alarm;
  } snap_t;
  localparam logic [7:0] CMD_FUNC      = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_HOME_ADDR = 8'h80;
  localparam logic [7:0] ASCII_COLON   = 8'h3A;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_STAR    = 8'h2A;
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    return idx == 3'd0 ? CMD_FUNC : idx == 3'd1 ? CMD_DISP_ON : idx == 3'd2 ? CMD_CLEAR : CMD_ENTRY;
  endfunction
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input snap_t s);
    case (idx)
      3'd0:    return CMD_HOME_ADDR;
      3'd1:    return s.ms_hr;
      3'd2:    return s.ls_hr;
      3'd3:    return ASCII_COLON;
      3'd4:    return s.ms_min;
      3'd5:    return s.ls_min;
      3'd6:    return ASCII_SPACE;
      default: return s.alarm ? ASCII_STAR : ASCII_SPACE;
    endcase
  endfunction
endpackage

// File: rtl/aclk_lcd_xfer.sv
// aclk_lcd_xfer: one LCD bus transfer (setup, E pulse, post-E wait) with start/done handshake.
module aclk_lcd_xfer #(
  parameter int SETUP_CYC      = 2,
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);
  localparam int SHORT_LEN = SETUP_CYC + E_PULSE_CYC + CMD_WAIT_CYC;
  localparam int LONG_LEN  = SETUP_CYC + E_PULSE_CYC + CLEAR_WAIT_CYC;
  localparam int MAX_LEN   = LONG_LEN > SHORT_LEN ? LONG_LEN : SHORT_LEN;
  localparam int CW        = $clog2(MAX_LEN + 1);
  logic          r_busy, r_long, r_e, r_rs;
  logic [7:0]    r_data;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_accept, w_run;
  assign done      = r_busy && (r_cnt == (r_long ? CW'(LONG_LEN - 1) : CW'(SHORT_LEN - 1)));
  assign w_accept  = start && (!r_busy || done);
  assign w_run     = w_accept || (r_busy && !done);
  // r_cnt counts cycles since T0; a back-to-back start restarts it in the done cycle
  assign w_cnt_nxt = w_accept ? '0 : r_cnt + CW'(r_busy && !done);
  always_ff @(posedge clk)
    if (rst) begin
      r_busy <= 1'b0;
      r_long <= 1'b0;
      r_e    <= 1'b0;
      r_rs   <= 1'b0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_run;
      r_cnt  <= w_cnt_nxt;
      r_e    <= w_run && w_cnt_nxt >= CW'(SETUP_CYC) && w_cnt_nxt < CW'(SETUP_CYC + E_PULSE_CYC);
      if (w_accept) begin
        r_rs   <= rs;
        r_data <= data;
        r_long <= long_wait;
      end
    end
  assign lcd_e    = r_e;
  assign lcd_rs   = r_rs;
  assign lcd_data = r_data;
endmodule

// File: rtl/aclk_lcd_sequencer.sv
// aclk_lcd_sequencer: HD44780 power-up/init, then rewrites the 7-char clock frame on any input change.
module aclk_lcd_sequencer
  import aclk_lcd_pkg::*;
#(
  parameter int PWRUP_CYC      = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ms_hr,
  input  logic [7:0] ls_hr,
  input  logic [7:0] ms_min,
  input  logic [7:0] ls_min,
  input  logic       sound_alarm,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       ready
);
  localparam int PW = $clog2(PWRUP_CYC + 1);
  state_t        r_state, w_nstate;
  logic [2:0]    r_idx, w_nidx;
  logic [PW-1:0] r_pwr;
  snap_t         r_snap, w_live;
  logic          w_start, w_done, w_rs;
  logic [7:0]    w_byte;
  assign w_live = {ms_hr, ls_hr, ms_min, ls_min, sound_alarm};
  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_start  = 1'b0;
    case (r_state)
      PWRUP: if (r_pwr == PW'(PWRUP_CYC - 1)) begin
        w_nstate = INIT;
        w_nidx   = 3'd0;
        w_start  = 1'b1;
      end
      INIT: if (w_done) begin
        w_nstate = r_idx == 3'd3 ? FRAME : INIT;
        w_nidx   = r_idx == 3'd3 ? 3'd0 : r_idx + 3'd1;
        w_start  = 1'b1;
      end
      FRAME: if (w_done) begin
        w_nstate = r_idx == 3'd7 ? IDLE : FRAME;
        w_nidx   = r_idx + 3'd1;
        w_start  = r_idx != 3'd7;
      end
      default: if (w_live != r_snap) begin
        w_nstate = FRAME;
        w_nidx   = 3'd0;
        w_start  = 1'b1;
      end
    endcase
  end
  // frame byte 0 is a constant command, so reading the not-yet-loaded snapshot on frame entry is safe
  assign w_rs   = w_nstate == FRAME && w_nidx != 3'd0;
  assign w_byte = w_nstate == INIT ? init_byte(w_nidx) : frame_byte(w_nidx, r_snap);
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= PWRUP;
      r_idx   <= '0;
      r_pwr   <= '0;
      r_snap  <= '0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_pwr   <= r_state == PWRUP ? r_pwr + PW'(1) : '0;
      if (r_state != FRAME && w_nstate == FRAME) r_snap <= w_live;
    end
  aclk_lcd_xfer #(
    .SETUP_CYC(SETUP_CYC),
    .E_PULSE_CYC(E_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_xfer (
    .clk(clk),
    .rst(rst),
    .start(w_start),
    .rs(w_rs),
    .data(w_byte),
    .long_wait(!w_rs && w_byte == CMD_CLEAR),
    .lcd_e(lcd_e),
    .lcd_rs(lcd_rs),
    .lcd_data(lcd_data),
    .done(w_done)
  );
  assign lcd_rw = 1'b0;
  assign ready  = r_state == IDLE;
endmodule
